// File: rtl/txaclbuf_arq.sv
// Per-link ping-pong TX ACL payload buffer with ARQN/FLOW driven bank switching and SEQN toggling.
// Latency: state, status and ack/error pulses land on the clk_6M edge after the strobe; read path is combinational.
// Backpressure: a write or commit into a full fill bank is dropped and reported on commit_err_p.
module txaclbuf_arq #(
    parameter int NLT   = 8,
    parameter int DEPTH = 64,
    parameter int LTW   = $clog2(NLT),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              bsm_cs,
    input  logic              bsm_we,
    input  logic [LTW-1:0]    bsm_lt,
    input  logic [AW-1:0]     bsm_addr,
    input  logic [31:0]       bsm_din,
    input  logic              bsm_commit_p,
    input  logic [9:0]        bsm_pylen,
    input  logic [LTW-1:0]    tx_lt,
    input  logic              tx_packet_st_p,
    input  logic              py_datperiod,
    input  logic [AW+4:0]     pybitcount,
    input  logic              rx_hdr_p,
    input  logic [LTW-1:0]    rx_lt,
    input  logic              rx_arqn,
    input  logic              rx_flow,
    input  logic              flush_p,
    input  logic [LTW-1:0]    flush_lt,
    output logic              lnctrl_txpybitin,
    output logic [31:0]       lnctrl_bufpacket,
    output logic              latchpyhead_p,
    output logic              txpk_seqn,
    output logic [9:0]        tx_pylenByte,
    output logic [NLT-1:0]    regi_txdatready,
    output logic [NLT-1:0]    regi_bufempty,
    output logic              ack_int_p,
    output logic [LTW-1:0]    ack_lt,
    output logic              commit_err_p
);
    localparam int MAW = LTW + 1 + AW;

    logic [31:0] mem [0:(1<<MAW)-1];

    logic [NLT-1:0]            act_q, act_d;
    logic [NLT-1:0]            wr_q, wr_d;
    logic [NLT-1:0]            sent_q, sent_d;
    logic [NLT-1:0]            stop_q, stop_d;
    logic [NLT-1:0]            seqn_q, seqn_d;
    logic [NLT-1:0][1:0]       full_q, full_d;
    logic [NLT-1:0][1:0][9:0]  pylen_q, pylen_d;

    logic           ack_hit, err_hit;
    logic           ack_q, err_q;
    logic [LTW-1:0] ack_lt_q;

    logic           wr_en;
    logic [MAW-1:0] wr_idx, rd_idx;
    logic [AW-1:0]  rd_word;
    logic [31:0]    rd_dat;

    // Per-link next state; every decision uses pre-cycle state so same-cycle events compose.
    always_comb begin
        act_d   = act_q;
        wr_d    = wr_q;
        sent_d  = sent_q;
        stop_d  = stop_q;
        seqn_d  = seqn_q;
        full_d  = full_q;
        pylen_d = pylen_q;
        ack_hit = 1'b0;
        err_hit = 1'b0;
        for (int l = 0; l < NLT; l++) begin
            if (flush_p && flush_lt == LTW'(l)) begin
                full_d[l] = 2'b00;
                sent_d[l] = 1'b0;
                stop_d[l] = 1'b0;
                act_d[l]  = 1'b0;
                wr_d[l]   = 1'b0;
            end else begin
                if (bsm_cs && bsm_we && bsm_lt == LTW'(l) && full_q[l][wr_q[l]])
                    err_hit = 1'b1;
                if (bsm_commit_p && bsm_lt == LTW'(l)) begin
                    if (!full_q[l][wr_q[l]]) begin
                        full_d[l][wr_q[l]]  = 1'b1;
                        pylen_d[l][wr_q[l]] = bsm_pylen;
                        wr_d[l]             = ~wr_q[l];
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                if (rx_hdr_p && rx_lt == LTW'(l))
                    stop_d[l] = ~rx_flow;
                // sent implies full[act], so an ACK never collides with an accepted commit's bank
                if (rx_hdr_p && rx_lt == LTW'(l) && rx_arqn && sent_q[l]) begin
                    full_d[l][act_q[l]] = 1'b0;
                    act_d[l]            = ~act_q[l];
                    seqn_d[l]           = ~seqn_q[l];
                    sent_d[l]           = 1'b0;
                    ack_hit             = 1'b1;
                end else if (tx_packet_st_p && tx_lt == LTW'(l) && full_q[l][act_q[l]]) begin
                    sent_d[l] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            act_q    <= '0;
            wr_q     <= '0;
            sent_q   <= '0;
            stop_q   <= '0;
            seqn_q   <= '1;
            full_q   <= '0;
            pylen_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ack_lt_q <= '0;
        end else begin
            act_q    <= act_d;
            wr_q     <= wr_d;
            sent_q   <= sent_d;
            stop_q   <= stop_d;
            seqn_q   <= seqn_d;
            full_q   <= full_d;
            pylen_q  <= pylen_d;
            ack_q    <= ack_hit;
            err_q    <= err_hit;
            if (ack_hit)
                ack_lt_q <= rx_lt;
        end
    end

    // A flushed link drops the same-cycle write along with everything else.
    assign wr_en  = bsm_cs && bsm_we && !full_q[bsm_lt][wr_q[bsm_lt]]
                    && !(flush_p && flush_lt == bsm_lt);
    assign wr_idx = {bsm_lt, wr_q[bsm_lt], bsm_addr};

    always_ff @(posedge clk_6M) begin
        if (wr_en)
            mem[wr_idx] <= bsm_din;
    end

    assign rd_word = pybitcount[AW+4:5];
    assign rd_idx  = {tx_lt, act_q[tx_lt], rd_word};
    assign rd_dat  = mem[rd_idx];

    assign lnctrl_bufpacket = py_datperiod ? rd_dat : 32'd0;
    assign lnctrl_txpybitin = lnctrl_bufpacket[pybitcount[4:0]];
    assign latchpyhead_p    = py_datperiod && (pybitcount == (AW+5)'(4));

    assign txpk_seqn    = seqn_q[tx_lt];
    assign tx_pylenByte = pylen_q[tx_lt][act_q[tx_lt]];
    assign ack_int_p    = ack_q;
    assign ack_lt       = ack_lt_q;
    assign commit_err_p = err_q;

    always_comb begin
        regi_txdatready = '0;
        regi_bufempty   = '0;
        for (int l = 0; l < NLT; l++) begin
            regi_txdatready[l] = full_q[l][act_q[l]] & ~stop_q[l];
            regi_bufempty[l]   = ~|full_q[l];
        end
    end

endmodule

// File: tb/tb_txaclbuf_arq.sv
// Randomized bench for txaclbuf_arq against a per-link commit/ack counting model.
module tb_txaclbuf_arq;
    localparam int NLT = 8;
    localparam int DEPTH = 64;
    localparam int LTW = 3;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rstz;
    logic bsm_cs, bsm_we, bsm_commit_p;
    logic [LTW-1:0] bsm_lt, tx_lt, rx_lt, flush_lt;
    logic [AW-1:0] bsm_addr;
    logic [31:0] bsm_din;
    logic [9:0] bsm_pylen;
    logic tx_packet_st_p, py_datperiod, rx_hdr_p, rx_arqn, rx_flow, flush_p;
    logic [AW+4:0] pybitcount;
    logic lnctrl_txpybitin, latchpyhead_p, txpk_seqn, ack_int_p, commit_err_p;
    logic [31:0] lnctrl_bufpacket;
    logic [9:0] tx_pylenByte;
    logic [NLT-1:0] regi_txdatready, regi_bufempty;
    logic [LTW-1:0] ack_lt;

    always #5 clk = ~clk;

    txaclbuf_arq #(.NLT(NLT), .DEPTH(DEPTH)) dut (
        .clk_6M(clk), .rstz(rstz),
        .bsm_cs(bsm_cs), .bsm_we(bsm_we), .bsm_lt(bsm_lt), .bsm_addr(bsm_addr),
        .bsm_din(bsm_din), .bsm_commit_p(bsm_commit_p), .bsm_pylen(bsm_pylen),
        .tx_lt(tx_lt), .tx_packet_st_p(tx_packet_st_p), .py_datperiod(py_datperiod),
        .pybitcount(pybitcount), .rx_hdr_p(rx_hdr_p), .rx_lt(rx_lt), .rx_arqn(rx_arqn),
        .rx_flow(rx_flow), .flush_p(flush_p), .flush_lt(flush_lt),
        .lnctrl_txpybitin(lnctrl_txpybitin), .lnctrl_bufpacket(lnctrl_bufpacket),
        .latchpyhead_p(latchpyhead_p), .txpk_seqn(txpk_seqn), .tx_pylenByte(tx_pylenByte),
        .regi_txdatready(regi_txdatready), .regi_bufempty(regi_bufempty),
        .ack_int_p(ack_int_p), .ack_lt(ack_lt), .commit_err_p(commit_err_p)
    );

    // Model: accepted commits and ACKs counted since the last flush; fill bank is the
    // commit count parity, send bank the ACK count parity, occupancy their difference.
    int cc [NLT];
    int ac [NLT];
    bit msent [NLT];
    bit mstop [NLT];
    bit mseqn [NLT];
    int lenq [NLT][$];
    logic [31:0] mmem [NLT][2][DEPTH];
    bit mval [NLT][2][DEPTH];
    bit exp_ack, exp_err;
    int exp_lt;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bsm_cs = 0; bsm_we = 0; bsm_lt = 0; bsm_addr = 0; bsm_din = 0;
        bsm_commit_p = 0; bsm_pylen = 0; tx_lt = 0; tx_packet_st_p = 0;
        py_datperiod = 0; pybitcount = 0; rx_hdr_p = 0; rx_lt = 0;
        rx_arqn = 0; rx_flow = 0; flush_p = 0; flush_lt = 0;
    endtask

    task automatic model_reset();
        for (int l = 0; l < NLT; l++) begin
            cc[l] = 0; ac[l] = 0; msent[l] = 0; mstop[l] = 0; mseqn[l] = 1;
            lenq[l].delete();
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < DEPTH; a++) mval[l][b][a] = 0;
        end
        exp_ack = 0; exp_err = 0; exp_lt = 0;
    endtask

    task automatic model_update();
        bit ack_any = 0;
        bit err_any = 0;
        int alt = 0;
        for (int l = 0; l < NLT; l++) begin
            int n;
            bit ack;
            if (flush_p && flush_lt == l) begin
                cc[l] = 0; ac[l] = 0; lenq[l].delete(); msent[l] = 0; mstop[l] = 0;
                continue;
            end
            n = cc[l] - ac[l];
            ack = rx_hdr_p && rx_lt == l && rx_arqn && msent[l];
            if (bsm_cs && bsm_we && bsm_lt == l) begin
                if (n < 2) begin
                    mmem[l][cc[l] % 2][bsm_addr] = bsm_din;
                    mval[l][cc[l] % 2][bsm_addr] = 1;
                end else err_any = 1;
            end
            if (bsm_commit_p && bsm_lt == l) begin
                if (n < 2) begin
                    lenq[l].push_back(int'(bsm_pylen));
                    cc[l]++;
                end else err_any = 1;
            end
            if (rx_hdr_p && rx_lt == l) mstop[l] = !rx_flow;
            if (ack) begin
                void'(lenq[l].pop_front());
                ac[l]++; mseqn[l] ^= 1'b1; msent[l] = 0; ack_any = 1; alt = l;
            end else if (tx_packet_st_p && tx_lt == l && n > 0) msent[l] = 1;
        end
        exp_ack = ack_any; exp_lt = alt; exp_err = err_any;
    endtask

    // Called in the low phase with inputs already applied; returns at the next negedge.
    task automatic run_cycle();
        logic [NLT-1:0] er, ee;
        logic [AW-1:0] w;
        int bank;
        #1;
        for (int l = 0; l < NLT; l++) begin
            er[l] = (cc[l] - ac[l] > 0) && !mstop[l];
            ee[l] = (cc[l] == ac[l]);
        end
        chk("txdatready", 32'(regi_txdatready), 32'(er));
        chk("bufempty", 32'(regi_bufempty), 32'(ee));
        chk("seqn", 32'(txpk_seqn), 32'(mseqn[tx_lt]));
        if (cc[tx_lt] - ac[tx_lt] > 0) chk("pylen", 32'(tx_pylenByte), 32'(lenq[tx_lt][0]));
        chk("ack_int_p", 32'(ack_int_p), 32'(exp_ack));
        if (exp_ack) chk("ack_lt", 32'(ack_lt), 32'(exp_lt));
        chk("commit_err_p", 32'(commit_err_p), 32'(exp_err));
        chk("latchpyhead", 32'(latchpyhead_p), 32'(py_datperiod && pybitcount == 4));
        w = pybitcount[AW+4:5];
        bank = ac[tx_lt] % 2;
        if (!py_datperiod) chk("pkt_idle", lnctrl_bufpacket, 32'd0);
        else if (mval[tx_lt][bank][w]) begin
            chk("pkt_word", lnctrl_bufpacket, mmem[tx_lt][bank][w]);
            chk("pkt_bit", 32'(lnctrl_txpybitin), 32'(mmem[tx_lt][bank][w][pybitcount[4:0]]));
        end
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstz = 0;
        idle();
        #1;
        model_reset();
        chk("rst_empty", 32'(regi_bufempty), 32'(8'hFF));
        chk("rst_ready", 32'(regi_txdatready), 32'd0);
        chk("rst_seqn", 32'(txpk_seqn), 32'd1);
        chk("rst_ack", 32'(ack_int_p), 32'd0);
        chk("rst_err", 32'(commit_err_p), 32'd0);
        #1 rstz = 1;
    endtask

    task automatic commit(input int lt, input int len);
        idle(); bsm_lt = LTW'(lt); bsm_commit_p = 1; bsm_pylen = 10'(len); run_cycle();
    endtask

    task automatic write(input int lt, input int addr, input logic [31:0] d);
        idle(); bsm_cs = 1; bsm_we = 1; bsm_lt = LTW'(lt); bsm_addr = AW'(addr); bsm_din = d;
        run_cycle();
    endtask

    task automatic txst(input int lt);
        idle(); tx_lt = LTW'(lt); tx_packet_st_p = 1; run_cycle();
    endtask

    task automatic rxhdr(input int lt, input bit arqn, input bit flow);
        idle(); rx_hdr_p = 1; rx_lt = LTW'(lt); rx_arqn = arqn; rx_flow = flow; run_cycle();
    endtask

    initial begin
        logic [31:0] pat;
        rstz = 0;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Two payloads on LT 3, send, ACK: bank and SEQN advance.
        write(3, 0, 32'h1111_0000);
        commit(3, 17);
        write(3, 0, 32'h2222_0003);
        commit(3, 200);
        txst(3);
        rxhdr(3, 1, 1);
        idle(); tx_lt = 3; #1;
        chk("ack_seqn", 32'(txpk_seqn), 32'd0);
        chk("ack_pylen", 32'(tx_pylenByte), 32'd200);
        chk("ack_pulse", 32'(ack_int_p), 32'd1);
        chk("ack_lt3", 32'(ack_lt), 32'd3);
        run_cycle();

        // NAK: retransmit the same bank.
        txst(3);
        rxhdr(3, 0, 1);
        idle(); tx_lt = 3; py_datperiod = 1; pybitcount = 0; #1;
        chk("nak_word", lnctrl_bufpacket, 32'h2222_0003);
        chk("nak_seqn", 32'(txpk_seqn), 32'd0);
        run_cycle();

        // Fill both banks, reject a third commit, then commit+ACK in one cycle.
        commit(3, 33);
        commit(3, 44);
        idle(); #1;
        chk("both_full_err", 32'(commit_err_p), 32'd1);
        run_cycle();
        txst(3);
        idle(); bsm_lt = 3; bsm_commit_p = 1; bsm_pylen = 55;
        rx_hdr_p = 1; rx_lt = 3; rx_arqn = 1; rx_flow = 1; run_cycle();
        idle(); tx_lt = 3; #1;
        chk("ack_commit_err", 32'(commit_err_p), 32'd1);
        chk("ack_commit_len", 32'(tx_pylenByte), 32'd33);
        run_cycle();

        // Bit-serial readout on LT 5.
        write(5, 0, 32'hA5A5_0001);
        pat = 32'hA5A5_0001;
        for (int i = 0; i < 32; i++) begin
            idle(); tx_lt = 5; py_datperiod = 1; pybitcount = 11'(i); #1;
            chk("serial", 32'(lnctrl_txpybitin), 32'(pat[i]));
            run_cycle();
        end

        // FLOW stop / go on LT 3.
        rxhdr(3, 0, 0);
        idle(); #1;
        chk("flow_stop", 32'(regi_txdatready[3]), 32'd0);
        run_cycle();
        rxhdr(3, 0, 1);
        idle(); #1;
        chk("flow_go", 32'(regi_txdatready[3]), 32'd1);
        run_cycle();

        // Flush LT 2 while LT 6 is ACKed.
        commit(2, 10);
        commit(6, 20);
        commit(6, 30);
        txst(6);
        idle(); flush_p = 1; flush_lt = 2; rx_hdr_p = 1; rx_lt = 6; rx_arqn = 1; rx_flow = 1;
        run_cycle();
        idle(); tx_lt = 2; #1;
        chk("flush_empty", 32'(regi_bufempty[2]), 32'd1);
        chk("flush_seqn", 32'(txpk_seqn), 32'd1);
        tx_lt = 6; #1;
        chk("lt6_seqn", 32'(txpk_seqn), 32'd0);
        chk("lt6_len", 32'(tx_pylenByte), 32'd30);
        run_cycle();

        // Random traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            idle();
            bsm_lt = LTW'($urandom_range(0, NLT-1));
            if ($urandom_range(0, 99) < 30) begin
                bsm_cs = 1; bsm_we = 1;
                bsm_addr = AW'($urandom_range(0, 3)); bsm_din = $urandom;
            end
            bsm_commit_p = ($urandom_range(0, 99) < 20);
            bsm_pylen = 10'($urandom);
            tx_lt = LTW'($urandom_range(0, NLT-1));
            tx_packet_st_p = ($urandom_range(0, 99) < 25);
            py_datperiod = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 5) pybitcount = 4;
            else pybitcount = 11'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
            rx_hdr_p = ($urandom_range(0, 99) < 25);
            rx_lt = LTW'($urandom_range(0, NLT-1));
            rx_arqn = ($urandom_range(0, 99) < 70);
            rx_flow = ($urandom_range(0, 99) < 80);
            flush_p = ($urandom_range(0, 99) < 2);
            flush_lt = LTW'($urandom_range(0, NLT-1));
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
